// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit access into two
// 16-bit halfword phases on an external asynchronous SRAM, freezing the pipeline via ready.
module mem_stage_sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              op_write, op_write_next;
  logic [ADDR_W-2:0] word, word_next;
  logic [15:0]       wdata_hi, wdata_hi_next;
  logic [31:0]       rdata_next;
  logic [ADDR_W-1:0] sram_addr_next;
  logic [15:0]       sram_dq_out_next;
  logic              sram_dq_oe_next;
  logic              sram_ce_n_next;
  logic              sram_we_n_next;
  logic              sram_oe_n_next;
  logic              req;
  logic              phase_end;

  assign req       = rd_en | wr_en;
  assign phase_end = (cnt == LAST);

  // Holding rst forces ready high so a request held across reset cannot freeze the pipeline
  assign ready = rst | ~(((state == IDLE) && req) || (state == LOW) || (state == HIGH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      word        <= '0;
      wdata_hi    <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      op_write    <= op_write_next;
      word        <= word_next;
      wdata_hi    <= wdata_hi_next;
      rdata       <= rdata_next;
      sram_addr   <= sram_addr_next;
      sram_dq_out <= sram_dq_out_next;
      sram_dq_oe  <= sram_dq_oe_next;
      sram_ce_n   <= sram_ce_n_next;
      sram_we_n   <= sram_we_n_next;
      sram_oe_n   <= sram_oe_n_next;
    end
  end

  // Pin values are computed one cycle ahead so they switch exactly at phase boundaries
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    op_write_next    = op_write;
    word_next        = word;
    wdata_hi_next    = wdata_hi;
    rdata_next       = rdata;
    sram_addr_next   = sram_addr;
    sram_dq_out_next = sram_dq_out;
    sram_dq_oe_next  = sram_dq_oe;
    sram_ce_n_next   = sram_ce_n;
    sram_we_n_next   = sram_we_n;
    sram_oe_n_next   = sram_oe_n;

    case (state)
      IDLE: begin
        if (req) begin
          op_write_next  = wr_en;
          word_next      = address[ADDR_W:2];
          wdata_hi_next  = wdata[31:16];
          cnt_next       = '0;
          state_next     = LOW;
          sram_addr_next = {address[ADDR_W:2], 1'b0};
          sram_ce_n_next = 1'b0;
          sram_we_n_next = ~wr_en;
          sram_oe_n_next = wr_en;
          sram_dq_oe_next = wr_en;
          if (wr_en) begin
            sram_dq_out_next = wdata[15:0];
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          cnt_next       = '0;
          state_next     = HIGH;
          sram_addr_next = {word, 1'b1};
          if (op_write) begin
            sram_dq_out_next = wdata_hi;
          end else begin
            rdata_next[15:0] = sram_dq_in;
          end
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          cnt_next        = '0;
          state_next      = DONE;
          sram_ce_n_next  = 1'b1;
          sram_we_n_next  = 1'b1;
          sram_oe_n_next  = 1'b1;
          sram_dq_oe_next = 1'b0;
          if (!op_write) begin
            rdata_next[31:16] = sram_dq_in;
          end
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
